// File: rtl/operand_stage.sv
// Operand-select stage: decodes the opcode into two VW-bit operands and buffers up to two entries.
// Optional macro OPERAND_STAGE_FLUSH_EN adds a synchronous flush input that empties the buffer.
module operand_stage #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16,
  parameter int OFF_W  = 6,
  parameter int IMM_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef OPERAND_STAGE_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                functype,
  input  logic [LANES*LANE_W-1:0]   vec1,
  input  logic [LANES*LANE_W-1:0]   vec2,
  input  logic [LANE_W-1:0]         sc1,
  input  logic [LANE_W-1:0]         sc2,
  input  logic [LANE_W-1:0]         pc,
  input  logic [OFF_W-1:0]          offset,
  input  logic [IMM_W-1:0]          immediate,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_op1,
  output logic [LANES*LANE_W-1:0]   out_op2,
  output logic [3:0]                out_functype,
  output logic                      out_err,
  output logic [1:0]                occupancy
);
  localparam int VW = LANES * LANE_W;

  localparam logic [3:0] F_VADD = 4'b0000, F_VDOT = 4'b0001, F_SMUL = 4'b0010,
                         F_SST  = 4'b0011, F_VLD  = 4'b0100, F_VST  = 4'b0101,
                         F_SLL  = 4'b0110, F_SLH  = 4'b0111, F_J    = 4'b1000,
                         F_NOP  = 4'b1111;

  // Slot 0 is always the head; slot 1 only holds data when two entries are buffered.
  logic [VW-1:0] op1_reg [2];
  logic [VW-1:0] op2_reg [2];
  logic [3:0]    ft_reg  [2];
  logic          err_reg [2];
  logic [1:0]    occ_reg, occ_next;

  logic          flush_req;
  logic          push, pop, wr0, wr1, shift;
  logic [VW-1:0] new_op1, new_op2;
  logic          new_err;
  logic [LANE_W-1:0] off_sx, imm_zx, imm_sx;

`ifdef OPERAND_STAGE_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready  = (occ_reg != 2'd2) && !flush_req;
  assign out_valid = (occ_reg != 2'd0);
  assign occupancy = occ_reg;
  assign push      = in_valid && in_ready && (functype != F_NOP);
  assign pop       = out_valid && out_ready;

  assign off_sx = LANE_W'($signed(offset));
  assign imm_zx = LANE_W'(immediate);
  assign imm_sx = LANE_W'($signed(immediate));

  always_comb begin
    new_op1 = '0;
    new_op2 = '0;
    new_err = 1'b0;
    case (functype)
      F_VADD, F_VDOT: begin new_op1 = vec1;    new_op2 = vec2;        end
      F_SMUL:         begin new_op1 = VW'(sc1); new_op2 = VW'(sc2);    end
      F_SST, F_VLD, F_VST:
                      begin new_op1 = VW'(sc1); new_op2 = VW'(off_sx); end
      F_SLL, F_SLH:   begin new_op1 = VW'(sc1); new_op2 = VW'(imm_zx); end
      F_J:            begin new_op1 = VW'(pc);  new_op2 = VW'(imm_sx); end
      default:        new_err = 1'b1;
    endcase
  end

  always_comb begin
    shift = pop && (occ_reg == 2'd2);
    wr0   = push && ((occ_reg == 2'd0) || ((occ_reg == 2'd1) && pop));
    wr1   = push && (occ_reg == 2'd1) && !pop;
    occ_next = occ_reg;
    if (push && !pop)
      occ_next = occ_reg + 2'd1;
    else if (!push && pop)
      occ_next = occ_reg - 2'd1;
    if (flush_req)
      occ_next = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        op1_reg[i] <= '0;
        op2_reg[i] <= '0;
        ft_reg[i]  <= '0;
        err_reg[i] <= 1'b0;
      end
    end else begin
      occ_reg <= occ_next;
      if (wr0) begin
        op1_reg[0] <= new_op1;
        op2_reg[0] <= new_op2;
        ft_reg[0]  <= functype;
        err_reg[0] <= new_err;
      end else if (shift) begin
        op1_reg[0] <= op1_reg[1];
        op2_reg[0] <= op2_reg[1];
        ft_reg[0]  <= ft_reg[1];
        err_reg[0] <= err_reg[1];
      end
      if (wr1) begin
        op1_reg[1] <= new_op1;
        op2_reg[1] <= new_op2;
        ft_reg[1]  <= functype;
        err_reg[1] <= new_err;
      end
    end
  end

  // Stale slot contents never leak: outputs read as zero whenever the buffer is empty.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign out_op1[gi*LANE_W +: LANE_W] = out_valid ? op1_reg[0][gi*LANE_W +: LANE_W] : '0;
    assign out_op2[gi*LANE_W +: LANE_W] = out_valid ? op2_reg[0][gi*LANE_W +: LANE_W] : '0;
  end
  assign out_functype = out_valid ? ft_reg[0] : 4'd0;
  assign out_err      = out_valid ? err_reg[0] : 1'b0;

endmodule
